// File: rtl/sram_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of an asynchronous 16-bit SRAM.
// Round-robin on ties, one access at a time, all SRAM strobes registered.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        io_mainClk,
  input  logic        io_asyncResetn,
  input  logic        io_a_valid,
  output logic        io_a_ready,
  input  logic        io_a_write,
  input  logic [17:0] io_a_addr,
  input  logic [15:0] io_a_wdata,
  input  logic [1:0]  io_a_mask,
  output logic        io_a_rsp_valid,
  output logic [15:0] io_a_rdata,
  input  logic        io_b_valid,
  output logic        io_b_ready,
  input  logic        io_b_write,
  input  logic [17:0] io_b_addr,
  input  logic [15:0] io_b_wdata,
  input  logic [1:0]  io_b_mask,
  output logic        io_b_rsp_valid,
  output logic [15:0] io_b_rdata,
  output logic [17:0] io_sram_addr,
  output logic [15:0] io_sram_dat_write,
  output logic        io_sram_dat_writeEnable,
  input  logic [15:0] io_sram_dat_read,
  output logic        io_sram_cs,
  output logic        io_sram_we,
  output logic        io_sram_oe,
  output logic        io_sram_ub,
  output logic        io_sram_lb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state, next_state;
  logic [3:0]  count;
  logic        last_cnt;
  logic        last_grant;
  logic        cur_port;
  logic        cur_write;
  logic [1:0]  cur_mask;
  logic        accept;
  logic        sel_write, nxt_write;
  logic [1:0]  sel_mask, nxt_mask;
  logic [17:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        cs_d, we_d, oe_d, ub_d, lb_d, wen_d;

  assign last_cnt = (count == 4'(WAIT_CYCLES - 1));

  // last_grant: 0 = A, 1 = B; on a tie the port not served last wins
  always_comb begin
    io_a_ready = (state == IDLE) && io_a_valid && (!io_b_valid || last_grant);
    io_b_ready = (state == IDLE) && io_b_valid && (!io_a_valid || !last_grant);
    accept     = io_a_ready || io_b_ready;
    sel_write  = io_b_ready ? io_b_write : io_a_write;
    sel_addr   = io_b_ready ? io_b_addr  : io_a_addr;
    sel_wdata  = io_b_ready ? io_b_wdata : io_a_wdata;
    sel_mask   = io_b_ready ? io_b_mask  : io_a_mask;
  end

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) state <= IDLE;
    else                 state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (last_cnt) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobe values for the coming cycle; registered below so pins never glitch
  always_comb begin
    nxt_write = (state == IDLE) ? sel_write : cur_write;
    nxt_mask  = (state == IDLE) ? sel_mask  : cur_mask;
    cs_d  = 1'b1;
    we_d  = 1'b1;
    oe_d  = 1'b1;
    ub_d  = 1'b1;
    lb_d  = 1'b1;
    wen_d = 1'b0;
    case (next_state)
      SETUP, ACCESS: begin
        cs_d = 1'b0;
        ub_d = ~nxt_mask[1];
        lb_d = ~nxt_mask[0];
        if (nxt_write) begin
          wen_d = 1'b1;
          we_d  = (next_state != ACCESS);
        end else begin
          oe_d = 1'b0;
        end
      end
      DONE:    wen_d = cur_write;
      default: ;
    endcase
  end

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      count                   <= '0;
      last_grant              <= 1'b1;
      cur_port                <= 1'b0;
      cur_write               <= 1'b0;
      cur_mask                <= '0;
      io_sram_addr            <= '0;
      io_sram_dat_write       <= '0;
      io_sram_dat_writeEnable <= 1'b0;
      io_sram_cs              <= 1'b1;
      io_sram_we              <= 1'b1;
      io_sram_oe              <= 1'b1;
      io_sram_ub              <= 1'b1;
      io_sram_lb              <= 1'b1;
      io_a_rsp_valid          <= 1'b0;
      io_b_rsp_valid          <= 1'b0;
      io_a_rdata              <= '0;
      io_b_rdata              <= '0;
    end else begin
      io_sram_cs              <= cs_d;
      io_sram_we              <= we_d;
      io_sram_oe              <= oe_d;
      io_sram_ub              <= ub_d;
      io_sram_lb              <= lb_d;
      io_sram_dat_writeEnable <= wen_d;
      if (accept) begin
        cur_port          <= io_b_ready;
        cur_write         <= sel_write;
        cur_mask          <= sel_mask;
        last_grant        <= io_b_ready;
        io_sram_addr      <= sel_addr;
        io_sram_dat_write <= sel_wdata;
      end
      // Saturating by construction: cleared outside ACCESS, stops at the last cycle
      if (state == ACCESS && !last_cnt) count <= count + 4'd1;
      else                              count <= '0;
      io_a_rsp_valid <= (next_state == DONE) && !cur_port;
      io_b_rsp_valid <= (next_state == DONE) &&  cur_port;
      if (state == ACCESS && last_cnt && !cur_write) begin
        if (cur_port) io_b_rdata <= io_sram_dat_read;
        else          io_a_rdata <= io_sram_dat_read;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: SRAM behavioural model, reference memory
// and per-port response scoreboards; a second instance runs WAIT_CYCLES=1.
module tb_sram_arbiter;

  localparam int W = 2;

  typedef struct {
    logic        wr;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk, rst_n;
  logic a_valid, a_ready, a_write, a_rsp_valid;
  logic b_valid, b_ready, b_write, b_rsp_valid;
  logic [17:0] a_addr, b_addr, s_addr;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata, s_dw, s_rd;
  logic [1:0]  a_mask, b_mask;
  logic s_wen, s_cs, s_we, s_oe, s_ub, s_lb;

  logic d1_b_valid, d1_b_ready, d1_a_ready, d1_a_rsp, d1_b_rsp;
  logic [17:0] d1_b_addr, d1_addr;
  logic [15:0] d1_a_rdata, d1_b_rdata, d1_dw, d1_rd;
  logic d1_wen, d1_cs, d1_we, d1_oe, d1_ub, d1_lb;

  logic [15:0] mem     [0:1023];
  logic [15:0] ref_mem [0:1023];

  exp_t qa[$], qb[$], qc[$];
  int   glog_port[$], glog_cyc[$], acc1_cyc[$];
  int   compared = 0, mismatched = 0, cyc = 0;
  int   cs_low = 0, we_low = 0, oe_low = 0, ub_low = 0, lb_low = 0;
  int   a_ready_hi = 0, a_rsp_cnt = 0, b_rsp_cnt = 0, d1_ready_hi = 0;
  logic [17:0] cur_addr;
  logic [15:0] cur_wdata;
  logic [1:0]  cur_mask;
  logic        cur_write;

  sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .io_mainClk(clk), .io_asyncResetn(rst_n),
    .io_a_valid(a_valid), .io_a_ready(a_ready), .io_a_write(a_write),
    .io_a_addr(a_addr), .io_a_wdata(a_wdata), .io_a_mask(a_mask),
    .io_a_rsp_valid(a_rsp_valid), .io_a_rdata(a_rdata),
    .io_b_valid(b_valid), .io_b_ready(b_ready), .io_b_write(b_write),
    .io_b_addr(b_addr), .io_b_wdata(b_wdata), .io_b_mask(b_mask),
    .io_b_rsp_valid(b_rsp_valid), .io_b_rdata(b_rdata),
    .io_sram_addr(s_addr), .io_sram_dat_write(s_dw),
    .io_sram_dat_writeEnable(s_wen), .io_sram_dat_read(s_rd),
    .io_sram_cs(s_cs), .io_sram_we(s_we), .io_sram_oe(s_oe),
    .io_sram_ub(s_ub), .io_sram_lb(s_lb)
  );

  sram_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
    .io_mainClk(clk), .io_asyncResetn(rst_n),
    .io_a_valid(1'b0), .io_a_ready(d1_a_ready), .io_a_write(1'b0),
    .io_a_addr(18'h0), .io_a_wdata(16'h0), .io_a_mask(2'b00),
    .io_a_rsp_valid(d1_a_rsp), .io_a_rdata(d1_a_rdata),
    .io_b_valid(d1_b_valid), .io_b_ready(d1_b_ready), .io_b_write(1'b0),
    .io_b_addr(d1_b_addr), .io_b_wdata(16'h0), .io_b_mask(2'b11),
    .io_b_rsp_valid(d1_b_rsp), .io_b_rdata(d1_b_rdata),
    .io_sram_addr(d1_addr), .io_sram_dat_write(d1_dw),
    .io_sram_dat_writeEnable(d1_wen), .io_sram_dat_read(d1_rd),
    .io_sram_cs(d1_cs), .io_sram_we(d1_we), .io_sram_oe(d1_oe),
    .io_sram_ub(d1_ub), .io_sram_lb(d1_lb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: byte-masked write while cs and we are low
  assign s_rd  = mem[s_addr[9:0]];
  assign d1_rd = d1_addr[15:0] ^ 16'hA5A5;
  always @(posedge clk) begin
    if (!s_cs && !s_we) begin
      if (!s_ub) mem[s_addr[9:0]][15:8] <= s_dw[15:8];
      if (!s_lb) mem[s_addr[9:0]][7:0]  <= s_dw[7:0];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pushes expectations on accept, pops them on rsp_valid
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] ublb_exp;
    if (!rst_n) begin
      qa.delete(); qb.delete(); qc.delete();
    end else begin
      if (!s_cs) cs_low++;
      if (!s_we) we_low++;
      if (!s_oe) oe_low++;
      if (!s_ub) ub_low++;
      if (!s_lb) lb_low++;
      if (a_ready) a_ready_hi++;
      if (d1_b_ready) d1_ready_hi++;
      if (!s_cs) begin
        ublb_exp = ~cur_mask;
        checkOutput("sram_addr", 32'(s_addr), 32'(cur_addr));
        checkOutput("sram_ublb", 32'({s_ub, s_lb}), 32'(ublb_exp));
        if (cur_write) checkOutput("sram_wdata", 32'(s_dw), 32'(cur_wdata));
        else           checkOutput("sram_wen_read", 32'(s_wen), 32'd0);
      end
      if (a_rsp_valid) begin
        a_rsp_cnt++;
        if (qa.size() == 0) checkOutput("a_orphan_rsp", 32'd1, 32'd0);
        else begin
          e = qa.pop_front();
          checkOutput("a_latency", cyc, e.due);
          if (!e.wr) checkOutput("a_rdata", 32'(a_rdata), 32'(e.data));
          else       checkOutput("a_done_wen", 32'(s_wen), 32'd1);
        end
      end
      if (b_rsp_valid) begin
        b_rsp_cnt++;
        if (qb.size() == 0) checkOutput("b_orphan_rsp", 32'd1, 32'd0);
        else begin
          e = qb.pop_front();
          checkOutput("b_latency", cyc, e.due);
          if (!e.wr) checkOutput("b_rdata", 32'(b_rdata), 32'(e.data));
          else       checkOutput("b_done_wen", 32'(s_wen), 32'd1);
        end
      end
      if ((a_valid && a_ready) || (b_valid && b_ready)) begin
        cur_write = b_ready ? b_write : a_write;
        cur_addr  = b_ready ? b_addr  : a_addr;
        cur_wdata = b_ready ? b_wdata : a_wdata;
        cur_mask  = b_ready ? b_mask  : a_mask;
        e.wr  = cur_write;
        e.due = cyc + W + 2;
        if (cur_write) begin
          if (cur_mask[1]) ref_mem[cur_addr[9:0]][15:8] = cur_wdata[15:8];
          if (cur_mask[0]) ref_mem[cur_addr[9:0]][7:0]  = cur_wdata[7:0];
          e.data = 16'h0;
        end else begin
          e.data = ref_mem[cur_addr[9:0]];
        end
        if (b_ready) qb.push_back(e); else qa.push_back(e);
        glog_port.push_back(b_ready ? 1 : 0);
        glog_cyc.push_back(cyc);
      end
      if (d1_b_rsp) begin
        if (qc.size() == 0) checkOutput("d1_orphan_rsp", 32'd1, 32'd0);
        else begin
          e = qc.pop_front();
          checkOutput("d1_latency", cyc, e.due);
          checkOutput("d1_rdata", 32'(d1_b_rdata), 32'(e.data));
        end
      end
      if (d1_b_valid && d1_b_ready) begin
        e.wr   = 1'b0;
        e.data = d1_b_addr[15:0] ^ 16'hA5A5;
        e.due  = cyc + 3;
        qc.push_back(e);
        acc1_cyc.push_back(cyc);
      end
    end
  end

  task automatic waitReady(input logic port);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? b_ready : a_ready) && n < 100);
    if (!(port ? b_ready : a_ready)) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic port, input logic wr, input logic [17:0] addr,
                               input logic [15:0] wdata, input logic [1:0] mask);
    @(posedge clk); #1;
    if (port) begin
      b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = wdata; b_mask = mask;
    end else begin
      a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wdata; a_mask = mask;
    end
    waitReady(port);
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulseReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int s0, s1, s2, g0, n;
    rst_n = 1'b0;
    a_valid = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_mask = 0;
    b_valid = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_mask = 0;
    d1_b_valid = 0; d1_b_addr = 0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_cs", 32'(s_cs), 32'd1);
    checkOutput("rst_we", 32'(s_we), 32'd1);
    checkOutput("rst_oe_ub_lb", 32'({s_oe, s_ub, s_lb}), 32'h7);
    checkOutput("rst_wen", 32'(s_wen), 32'd0);
    checkOutput("rst_addr", 32'(s_addr), 32'd0);
    checkOutput("rst_dat_write", 32'(s_dw), 32'd0);
    checkOutput("rst_rsp", 32'({a_rsp_valid, b_rsp_valid}), 32'd0);
    checkOutput("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] A write 0xBEEF then read back");
    s0 = cs_low; s1 = we_low;
    applyStimulus(1'b0, 1'b1, 18'h00010, 16'hBEEF, 2'b11);
    waitIdle();
    checkOutput("wr_cs_low_cycles", cs_low - s0, 3);
    checkOutput("wr_we_low_cycles", we_low - s1, 2);
    s0 = oe_low;
    applyStimulus(1'b0, 1'b0, 18'h00010, 16'h0000, 2'b11);
    waitIdle();
    checkOutput("rd_oe_low_cycles", oe_low - s0, 3);
    checkOutput("a_rdata_beef", 32'(a_rdata), 32'hBEEF);
    applyStimulus(1'b0, 1'b1, 18'h00011, 16'h1111, 2'b11);
    waitIdle();
    checkOutput("a_rdata_hold", 32'(a_rdata), 32'hBEEF);

    $display("[TB] lower-byte write");
    applyStimulus(1'b1, 1'b1, 18'h00020, 16'h1234, 2'b11);
    waitIdle();
    s0 = lb_low; s1 = ub_low;
    applyStimulus(1'b0, 1'b1, 18'h00020, 16'hABCD, 2'b01);
    waitIdle();
    checkOutput("mask_lb_low", lb_low - s0, 3);
    checkOutput("mask_ub_low", ub_low - s1, 0);
    checkOutput("mask_upper_kept", 32'(mem[10'h020]), 32'h12CD);
    applyStimulus(1'b1, 1'b0, 18'h00020, 16'h0000, 2'b11);
    waitIdle();
    checkOutput("b_rdata_masked", 32'(b_rdata), 32'h12CD);

    $display("[TB] valid dropped before acceptance");
    s0 = cs_low; s1 = a_rsp_cnt; s2 = a_ready_hi;
    @(posedge clk); #1;
    b_valid = 1'b1; b_write = 1'b0; b_addr = 18'h00020;
    waitReady(1'b1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    a_valid = 1'b1; a_write = 1'b1; a_addr = 18'h00030; a_wdata = 16'hDEAD; a_mask = 2'b11;
    repeat (2) @(posedge clk);
    #1 a_valid = 1'b0;
    waitIdle();
    checkOutput("drop_cs_low_cycles", cs_low - s0, 3);
    checkOutput("drop_no_a_rsp", a_rsp_cnt - s1, 0);
    checkOutput("drop_no_a_ready", a_ready_hi - s2, 0);

    $display("[TB] reset during B read access");
    s0 = b_rsp_cnt;
    @(posedge clk); #1;
    b_valid = 1'b1; b_write = 1'b0; b_addr = 18'h00020;
    waitReady(1'b1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_in_access", 32'({s_cs, s_oe}), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_strobes", 32'({s_cs, s_we, s_oe, s_ub, s_lb}), 32'h1F);
    checkOutput("abort_wen", 32'(s_wen), 32'd0);
    checkOutput("abort_rsp", 32'(b_rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] contention from reset");
    g0 = glog_port.size();
    a_valid = 1'b1; a_write = 1'b0; a_addr = 18'h00010;
    b_valid = 1'b1; b_write = 1'b0; b_addr = 18'h00020;
    n = 0;
    while (glog_port.size() < g0 + 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    waitIdle();
    checkOutput("abort_no_b_rsp", b_rsp_cnt - s0, 2);
    if (glog_port.size() < g0 + 4) checkOutput("contention_timeout", 32'd0, 32'd1);
    else begin
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("grant_order_%0d", k), glog_port[g0 + k], k % 2);
      for (int k = 1; k < 4; k++)
        checkOutput($sformatf("grant_interval_%0d", k), glog_cyc[g0 + k] - glog_cyc[g0 + k - 1], W + 3);
    end
    applyStimulus(1'b0, 1'b0, 18'h00010, 16'h0000, 2'b11);
    waitIdle();
    checkOutput("post_reset_a_read", 32'(a_rdata), 32'hBEEF);

    $display("[TB] B-only stream of 10 writes");
    g0 = glog_port.size(); s0 = a_ready_hi; s1 = a_rsp_cnt; s2 = b_rsp_cnt;
    @(posedge clk); #1;
    b_valid = 1'b1; b_write = 1'b1; b_mask = 2'b11;
    for (int i = 0; i < 10; i++) begin
      b_addr  = 18'h00100 + 18'(i);
      b_wdata = 16'h5000 + 16'(i);
      waitReady(1'b1);
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    waitIdle();
    checkOutput("bonly_no_a_ready", a_ready_hi - s0, 0);
    checkOutput("bonly_no_a_rsp", a_rsp_cnt - s1, 0);
    checkOutput("bonly_b_rsp_count", b_rsp_cnt - s2, 10);
    for (int k = 1; k < 10 && g0 + k < glog_cyc.size(); k++)
      checkOutput($sformatf("bonly_interval_%0d", k), glog_cyc[g0 + k] - glog_cyc[g0 + k - 1], W + 3);
    applyStimulus(1'b1, 1'b0, 18'h00105, 16'h0000, 2'b11);
    waitIdle();
    checkOutput("bonly_readback", 32'(b_rdata), 32'h5005);

    $display("[TB] WAIT_CYCLES=1 back-to-back B reads");
    g0 = acc1_cyc.size(); s0 = d1_ready_hi;
    @(posedge clk); #1;
    d1_b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d1_b_addr = 18'h00200 + 18'(i * 3);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!d1_b_ready && n < 100);
      if (!d1_b_ready) checkOutput("d1_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    d1_b_valid = 1'b0;
    waitIdle();
    checkOutput("d1_ready_cycles", d1_ready_hi - s0, 4);
    for (int k = 1; k < 4 && g0 + k < acc1_cyc.size(); k++)
      checkOutput($sformatf("d1_interval_%0d", k), acc1_cyc[g0 + k] - acc1_cyc[g0 + k - 1], 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, number of strobe cycles per access (legal 1..15).
REQ-002 SHALL have io_mainClk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have io_asyncResetn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have io_a_valid / io_b_valid  input  1  requester A (CPU) / B (DMA) command valid.
REQ-005 SHALL have io_a_ready / io_b_ready  output  1  command accepted when valid&&ready.
REQ-006 SHALL have io_a_write / io_b_write  input  1  1=write, 0=read.
REQ-007 SHALL have io_a_addr / io_b_addr  input  18  halfword address.
REQ-008 SHALL have io_a_wdata / io_b_wdata  input  16  write data.
REQ-009 SHALL have io_a_mask / io_b_mask  input  2  byte enables, bit1=upper, bit0=lower.
REQ-010 SHALL have io_a_rsp_valid / io_b_rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have io_a_rdata / io_b_rdata  output  16  read data, valid with rsp_valid.
REQ-012 SHALL have io_sram_addr  output  18; io_sram_dat_write  output  16; io_sram_dat_writeEnable  output  1; io_sram_dat_read  input  16.
REQ-013 SHALL have io_sram_cs, io_sram_we, io_sram_oe, io_sram_ub, io_sram_lb  output  1 each, active-low strobes.

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE.
REQ-015 Ready SHALL be high only in IDLE, only for the granted port, combinationally from the valids and lastGrant.
REQ-016 In IDLE: a single valid is granted; both valid grants the port not equal to lastGrant; no valid stays in IDLE.
REQ-017 On accept SHALL latch addr, wdata, mask, write and port id, set lastGrant to the port, enter SETUP.
REQ-018 All io_sram_* outputs SHALL be registered; no combinational path from requester inputs.
REQ-019 SETUP: cs=0, addr driven, ub/lb = ~mask; read: oe=0; write: dat_writeEnable=1, we=1.
REQ-020 ACCESS: as SETUP, plus we=0 for writes; an internal counter counts WAIT_CYCLES cycles then moves to DONE.
REQ-021 Reads SHALL sample io_sram_dat_read on the edge ending the last ACCESS cycle into the issuing port's rdata.
REQ-022 DONE: cs=1, oe=1, we=1; dat_writeEnable stays 1 for writes (data hold); the issuing port's rsp_valid=1 for exactly this cycle, reads and writes alike.
REQ-023 io_x_rdata SHALL hold its last value until the next read completes for that port.
REQ-024 Latency accept->rsp_valid SHALL be WAIT_CYCLES+2 cycles; issue interval WAIT_CYCLES+3 cycles.
REQ-025 Idle levels: cs=we=oe=ub=lb=1, dat_writeEnable=0, addr and dat_write hold their previous values.
REQ-026 A valid deasserted before acceptance SHALL be dropped with no SRAM activity.
REQ-027 The counter SHALL never wrap; WAIT_CYCLES=1 gives exactly one ACCESS cycle.

Reset
REQ-028 io_asyncResetn low SHALL immediately force IDLE, cs=we=oe=ub=lb=1, dat_writeEnable=0, rsp_valid=0, addr=0, dat_write=0, rdata=0, counter=0, lastGrant=B (A wins first tie).
REQ-029 Reset mid-access SHALL abort without rsp_valid; operation resumes on the first edge after release.

Verification
REQ-030 A write addr=0x00010, wdata=0xBEEF, mask=11, WAIT_CYCLES=2 -> we low 2 cycles, cs low 3, a_rsp_valid at accept+4, then A read returns 0xBEEF.
REQ-031 A and B valid together from reset -> A granted first, B next; continuous contention alternates A,B,A,B.
REQ-032 Write mask=01 -> lb=0, ub=1 throughout SETUP/ACCESS; upper byte of the SRAM model unchanged.
REQ-033 Reset pulsed during ACCESS of a B read -> strobes high at once, no b_rsp_valid, next A request served normally.
REQ-034 WAIT_CYCLES=1, back-to-back B reads -> rsp every 4 cycles, ready low in non-IDLE states.
REQ-035 Only B valid for 10 requests -> all granted, a_ready never high, a_rsp_valid never pulses.
